// File: rtl/misc_pkg.sv
// Shared definitions for the 8-bit core: instruction byte type and opcode encoding
// used by fetch, decode and their benches.
package misc_pkg;

  localparam int INSTR_W  = 8;
  localparam int OPCODE_W = 4;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_NOP = 4'd4
  } opcode_e;

  function automatic opcode_e instr_opcode(instr_t i);
    return opcode_e'(i[INSTR_W-1 -: OPCODE_W]);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries; flush empties it
// in one cycle and takes priority over any same-cycle push or pop.
module fetch_queue
  import misc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && (count != CNT_W'(DEPTH));
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (do_wr && !flush && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order instruction reads under a credit limit
// and buffers returned bytes for decode; a redirect restarts fetch down a new path.
module instr_fetch_unit
  import misc_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [7:0]        imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output instr_t            instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_rd_data;
  logic              req_fire;
  logic              rsp_accept;
  logic              rsp_keep;
  logic              deq;

  // In-flight plus buffered fetches never exceed DEPTH, so the queue cannot overflow.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid &&
                     (({1'b0, outstanding} + {1'b0, q_count}) < (CNT_W + 1)'(DEPTH));
    imem_req_addr  = rst ? RESET_PC : pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_accept     = imem_rsp_valid && (outstanding != '0);
    rsp_keep       = rsp_accept && (drop == '0) && !redirect_valid;
    instr_valid    = !rst && (q_count != '0);
    deq            = instr_valid && instr_ready && !redirect_valid;
    instr          = instr_valid ? q_rd_data[ADDR_W +: INSTR_W] : '0;
    instr_pc       = instr_valid ? q_rd_data[ADDR_W-1:0] : '0;
  end

  // On redirect every request still in flight after this edge belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      rsp_pc      <= redirect_pc;
      outstanding <= outstanding - CNT_W'(rsp_accept);
      drop        <= outstanding - CNT_W'(rsp_accept);
    end else begin
      if (req_fire) pc <= pc + 1'b1;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_accept);
      if (rsp_accept) begin
        if (drop != '0) drop <= drop - 1'b1;
        else            rsp_pc <= rsp_pc + 1'b1;
      end
    end
  end

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (rsp_keep),
    .wr_data ({imem_rsp_data, rsp_pc}),
    .rd_en   (deq),
    .rd_data (q_rd_data),
    .count   (q_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an in-order memory with variable latency
// and a request-tagging reference model, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req_valid;
  logic       imem_req_ready = 1'b0;
  logic [7:0] imem_req_addr;
  logic       imem_rsp_valid = 1'b0;
  logic [7:0] imem_rsp_data  = 8'h00;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc    = 8'h00;
  logic       instr_valid;
  logic       instr_ready    = 1'b0;
  logic [7:0] instr;
  logic [7:0] instr_pc;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    int         due;
    int         epoch;
  } req_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
  } ent_t;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  req_t       pend[$];
  ent_t       fq[$];
  logic [7:0] m_pc     = RESET_PC;
  int         epoch    = 0;
  int         last_due = 0;
  logic [7:0] key      = 8'h00;
  int         lat_min  = 1;
  int         lat_max  = 1;
  int         mready_pct = 100;
  int         iready_pct = 100;
  bit         spurious_en = 1'b0;
  bit         do_redirect = 1'b0;
  logic [7:0] redir_target = 8'h00;
  bit         do_reset = 1'b0;
  int         fires = 0;
  logic [7:0] cons_data[$];
  logic [7:0] cons_pc[$];

  function automatic logic [7:0] mem_byte(logic [7:0] a);
    return a ^ key;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkBound(string name, bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d wait bound expired", name, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model
  // by the effect of the coming rising edge.
  task automatic applyStimulus();
    bit         real_rsp;
    bit         exp_req_valid;
    bit         exp_instr_valid;
    req_t       r;
    int         due;
    @(negedge clk);
    rst            = do_reset;
    redirect_valid = do_redirect && !do_reset;
    redirect_pc    = redir_target;
    imem_req_ready = ($urandom_range(99) < 32'(mready_pct));
    instr_ready    = ($urandom_range(99) < 32'(iready_pct));
    real_rsp       = !do_reset && (pend.size() > 0) && (pend[0].due <= cyc);
    if (real_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_byte(pend[0].addr);
    end else begin
      imem_rsp_valid = spurious_en && !do_reset && (pend.size() == 0) && ($urandom_range(9) == 0);
      imem_rsp_data  = 8'($urandom);
    end
    #1;
    exp_req_valid   = !do_reset && !redirect_valid && ((pend.size() + fq.size()) < DEPTH);
    exp_instr_valid = !do_reset && (fq.size() > 0);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
    if (exp_req_valid) checkOutput("req_addr", 32'(imem_req_addr), 32'(m_pc));
    if (do_reset)      checkOutput("req_addr_rst", 32'(imem_req_addr), 32'(RESET_PC));
    checkOutput("instr_valid", 32'(instr_valid), 32'(exp_instr_valid));
    if (exp_instr_valid) begin
      checkOutput("instr", 32'(instr), 32'(fq[0].data));
      checkOutput("instr_pc", 32'(instr_pc), 32'(fq[0].pc));
    end else if (do_reset) begin
      checkOutput("instr_rst", 32'(instr), 32'h0);
      checkOutput("instr_pc_rst", 32'(instr_pc), 32'h0);
    end
    if (do_reset) begin
      pend.delete();
      fq.delete();
      m_pc     = RESET_PC;
      epoch++;
      last_due = 0;
    end else begin
      if (real_rsp) r = pend.pop_front();
      if (redirect_valid) begin
        fq.delete();
        epoch++;
        m_pc = redir_target;
      end else begin
        if (exp_instr_valid && instr_ready) begin
          cons_data.push_back(fq[0].data);
          cons_pc.push_back(fq[0].pc);
          void'(fq.pop_front());
        end
        if (real_rsp && r.epoch == epoch) fq.push_back('{data: mem_byte(r.addr), pc: r.addr});
        if (exp_req_valid && imem_req_ready) begin
          fires++;
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{addr: m_pc, due: due, epoch: epoch});
          m_pc = m_pc + 8'd1;
        end
      end
    end
    cyc++;
  endtask

  task automatic runCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    do_reset = 1'b1;
    runCycles(2);
    do_reset = 1'b0;
    cons_data.delete();
    cons_pc.delete();
    fires = 0;
  endtask

  task automatic doRedirect(logic [7:0] target);
    do_redirect  = 1'b1;
    redir_target = target;
    applyStimulus();
    do_redirect  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d simulation did not finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;

    // Streaming with 1-cycle memory, byte == address, decode always ready.
    key = 8'h00; lat_min = 1; lat_max = 1; mready_pct = 100; iready_pct = 100;
    doReset();
    applyStimulus();
    checkOutput("t1_first_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("t1_first_req_addr", 32'(imem_req_addr), 32'h00);
    runCycles(30);
    checkOutput("t1_consumed", 32'(cons_data.size()), 32'd29);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t1_instr_seq", 32'(cons_data[i]), 32'(i));
      checkOutput("t1_pc_seq", 32'(cons_pc[i]), 32'(i));
    end

    // Decode stalled: exactly DEPTH requests, then hold; release resumes in order.
    key = 8'h5A; iready_pct = 0;
    doReset();
    runCycles(20);
    checkOutput("t2_fires", 32'(fires), 32'd4);
    checkOutput("t2_req_stalled", 32'(imem_req_valid), 32'h0);
    checkOutput("t2_hold_valid", 32'(instr_valid), 32'h1);
    checkOutput("t2_hold_instr", 32'(instr), 32'h5A);
    iready_pct = 100;
    runCycles(20);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t2_resume_pc", 32'(cons_pc[i]), 32'(i));
      checkOutput("t2_resume_instr", 32'(cons_data[i]), 32'(i ^ 8'h5A));
    end

    // Latency 3: redirect while three requests are in flight.
    lat_min = 3; lat_max = 3;
    doReset();
    guard = 0;
    while (pend.size() != 3 && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkBound("t3_wait_inflight", pend.size() == 3);
    doRedirect(8'h40);
    cons_data.delete();
    cons_pc.delete();
    runCycles(15);
    checkOutput("t3_redirect_pc", 32'(cons_pc[0]), 32'h40);
    checkOutput("t3_redirect_instr", 32'(cons_data[0]), 32'h1A);

    // Redirect coinciding with a response and a dequeue.
    lat_min = 1; lat_max = 1;
    doReset();
    runCycles(5);
    checkOutput("t4_pre_valid", 32'(instr_valid), 32'h1);
    checkOutput("t4_pre_rsp", 32'(imem_rsp_valid), 32'h1);
    doRedirect(8'h80);
    cons_data.delete();
    cons_pc.delete();
    applyStimulus();
    checkOutput("t4_req_addr", 32'(imem_req_addr), 32'h80);
    checkOutput("t4_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("t4_flushed", 32'(instr_valid), 32'h0);
    runCycles(10);
    checkOutput("t4_first_pc", 32'(cons_pc[0]), 32'h80);

    // PC wrap across 0xFF.
    doReset();
    doRedirect(8'hFE);
    cons_data.delete();
    cons_pc.delete();
    runCycles(10);
    checkOutput("t5_pc0", 32'(cons_pc[0]), 32'hFE);
    checkOutput("t5_pc1", 32'(cons_pc[1]), 32'hFF);
    checkOutput("t5_pc2", 32'(cons_pc[2]), 32'h00);
    checkOutput("t5_instr2", 32'(cons_data[2]), 32'h5A);

    // Reset mid-stream with two buffered entries.
    iready_pct = 0;
    doReset();
    guard = 0;
    while (fq.size() != 2 && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkBound("t6_wait_buffered", fq.size() == 2);
    do_reset = 1'b1;
    applyStimulus();
    checkOutput("t6_rst_valid", 32'(instr_valid), 32'h0);
    do_reset = 1'b0;
    applyStimulus();
    checkOutput("t6_after_valid", 32'(instr_valid), 32'h0);
    checkOutput("t6_after_addr", 32'(imem_req_addr), 32'(RESET_PC));

    // Randomised traffic: variable latency, backpressure, redirects, resets, stray responses.
    key = 8'($urandom); lat_min = 1; lat_max = 3;
    mready_pct = 70; iready_pct = 60; spurious_en = 1'b1;
    doReset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 3) begin
        doRedirect(8'($urandom));
      end else if ($urandom_range(199) == 0) begin
        doReset();
      end else begin
        applyStimulus();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
